mem_stage: RTL and testbench

- RV64 memory-access pipeline stage, between execute and writeback.
- Performs loads and stores to data memory over a req/ack handshake, and aligns and sign- or zero-extends load data.
- Detects misaligned and access-fault conditions (LAM/LAF/SAM/SAF) and registers all results into the writeback-stage inputs.
- Stalls upstream while a data-memory transaction is outstanding.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/load_align.sv | 27 ++
 rtl/mem_stage.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64 encodings: memory opcodes, funct3 size codes, exception causes
// and small helpers for the access size.
package rv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [3:0] CAUSE_LAM = 4'd4;
    localparam logic [3:0] CAUSE_LAF = 4'd5;
    localparam logic [3:0] CAUSE_SAM = 4'd6;
    localparam logic [3:0] CAUSE_SAF = 4'd7;

    typedef enum logic {StIdle, StWait} mem_state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        size_bytes = 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: lane shift, truncate to access size, sign/zero extend.
module load_align
    import rv_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    result = shifted;
            F3_BU:   result = {56'b0, shifted[7:0]};
            F3_HU:   result = {48'b0, shifted[15:0]};
            F3_WU:   result = {32'b0, shifted[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: data-memory req/ack access, fault detection and WB registers.
module mem_stage
    import rv_pkg::*;
#(
    parameter logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] DMEM_SIZE = 64'h0000_0000_0001_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [63:0] MEM_NPC,
    input  logic [63:0] MEM_ALU_RESULT,
    input  logic [63:0] MEM_SR2,
    input  logic        MEM_BR_TAKEN,
    input  logic [63:0] MEM_RFD,
    input  logic [63:0] MEM_CSRFD,
    input  logic [4:0]  MEM_DRID,
    input  logic        MEM_ECALL,
    input  logic        FLUSH,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [7:0]  DMEM_BE,
    output logic [63:0] DMEM_WDATA,
    input  logic [63:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    input  logic        DMEM_ERR,
    output logic        MEM_STALL,
    output logic        WB_V,
    output logic [31:0] WB_IR,
    output logic [63:0] WB_NPC,
    output logic [63:0] WB_ALU_RESULT,
    output logic [63:0] WB_MEM_RESULT,
    output logic [63:0] WB_RFD,
    output logic [63:0] WB_CSRFD,
    output logic [4:0]  WB_DRID,
    output logic        WB_ECALL,
    output logic        MEM_PC_MUX,
    output logic        MEM_LAM,
    output logic        MEM_LAF,
    output logic        MEM_SAM,
    output logic        MEM_SAF
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             kill_q, is_load_q;
    logic [2:0]       f3_q, off_q;

    logic [63:0] addr;
    logic [2:0]  funct3;
    logic        is_load, is_store, memop;
    logic        illegal, misalign, out_of_range, acc_fault, mis_fault, pre_fault;
    logic [64:0] last_byte, limit;
    logic        timed_out, done, bus_fault, start, live, pass_v;
    logic [63:0] load_data;

    assign addr     = MEM_ALU_RESULT;
    assign funct3   = MEM_IR[14:12];
    assign is_load  = MEM_IR[6:0] == OP_LOAD;
    assign is_store = MEM_IR[6:0] == OP_STORE;
    assign memop    = is_load | is_store;

    always_comb begin
        illegal = is_load ? (funct3 == 3'b111) : funct3[2];
        case (funct3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            2'b11:   misalign = |addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Range check on the last byte so a straddling access faults.
    assign last_byte    = {1'b0, addr} + 65'(size_bytes(funct3[1:0])) - 65'd1;
    assign limit        = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};
    assign out_of_range = (addr < DMEM_BASE) || (last_byte >= limit);
    assign acc_fault    = illegal | (~misalign & out_of_range);
    assign mis_fault    = ~illegal & misalign;
    assign pre_fault    = acc_fault | mis_fault;

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    assign done      = (state_q == StWait) && (DMEM_ACK || DMEM_ERR || timed_out);
    assign bus_fault = DMEM_ERR | timed_out;
    assign start     = MEM_V & memop & ~pre_fault & ~FLUSH;
    assign MEM_STALL = start & ~done;
    assign live      = ~(kill_q | FLUSH);
    assign pass_v    = MEM_V & ~FLUSH;

    load_align u_load_align (
        .rdata  (DMEM_RDATA),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            kill_q        <= 1'b0;
            is_load_q     <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
            DMEM_REQ      <= 1'b0;
            DMEM_WE       <= 1'b0;
            DMEM_ADDR     <= '0;
            DMEM_BE       <= '0;
            DMEM_WDATA    <= '0;
            WB_V          <= 1'b0;
            WB_IR         <= '0;
            WB_NPC        <= '0;
            WB_ALU_RESULT <= '0;
            WB_MEM_RESULT <= '0;
            WB_RFD        <= '0;
            WB_CSRFD      <= '0;
            WB_DRID       <= '0;
            WB_ECALL      <= 1'b0;
            MEM_PC_MUX    <= 1'b0;
            MEM_LAM       <= 1'b0;
            MEM_LAF       <= 1'b0;
            MEM_SAM       <= 1'b0;
            MEM_SAF       <= 1'b0;
        end else begin
            // Pass-through fields track MEM every cycle; WB_V decides if they matter.
            WB_IR         <= MEM_IR;
            WB_NPC        <= MEM_NPC;
            WB_ALU_RESULT <= MEM_ALU_RESULT;
            WB_RFD        <= MEM_RFD;
            WB_CSRFD      <= MEM_CSRFD;
            WB_DRID       <= MEM_DRID;
            WB_ECALL      <= MEM_ECALL;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StWait;
                        cnt_q         <= '0;
                        kill_q        <= 1'b0;
                        is_load_q     <= is_load;
                        f3_q          <= funct3;
                        off_q         <= addr[2:0];
                        DMEM_REQ      <= 1'b1;
                        DMEM_WE       <= is_store;
                        DMEM_ADDR     <= {addr[63:3], 3'b000};
                        DMEM_BE       <= size_mask(funct3[1:0]) << addr[2:0];
                        DMEM_WDATA    <= is_store ? (MEM_SR2 << {addr[2:0], 3'b000}) : '0;
                        WB_V          <= 1'b0;
                        WB_MEM_RESULT <= '0;
                        MEM_PC_MUX    <= 1'b0;
                        {MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF} <= 4'b0000;
                    end else begin
                        WB_V          <= pass_v;
                        WB_MEM_RESULT <= '0;
                        MEM_PC_MUX    <= pass_v & MEM_BR_TAKEN;
                        MEM_LAM       <= pass_v & is_load & mis_fault;
                        MEM_LAF       <= pass_v & is_load & acc_fault;
                        MEM_SAM       <= pass_v & is_store & mis_fault;
                        MEM_SAF       <= pass_v & is_store & acc_fault;
                    end
                end
                StWait: begin
                    if (done) begin
                        state_q       <= StIdle;
                        kill_q        <= 1'b0;
                        DMEM_REQ      <= 1'b0;
                        DMEM_WE       <= 1'b0;
                        DMEM_ADDR     <= '0;
                        DMEM_BE       <= '0;
                        DMEM_WDATA    <= '0;
                        WB_V          <= live;
                        WB_MEM_RESULT <= (live & is_load_q & ~bus_fault) ? load_data : '0;
                        MEM_PC_MUX    <= 1'b0;
                        MEM_LAM       <= 1'b0;
                        MEM_SAM       <= 1'b0;
                        MEM_LAF       <= live & is_load_q & bus_fault;
                        MEM_SAF       <= live & ~is_load_q & bus_fault;
                    end else begin
                        if (FLUSH) kill_q <= 1'b1;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        WB_V       <= 1'b0;
                        MEM_PC_MUX <= 1'b0;
                        {MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF} <= 4'b0000;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized loads/stores
// checked against a byte-level reference model of the access rules.
module tb_mem_stage;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SIZE = 64'h0000_0000_0001_0000;
    localparam int          TO   = 255;
    localparam logic [6:0]  OPC_LD = 7'b0000011;
    localparam logic [6:0]  OPC_ST = 7'b0100011;

    logic        CLK, RESET, MEM_V, MEM_BR_TAKEN, MEM_ECALL, FLUSH;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_RFD, MEM_CSRFD;
    logic [4:0]  MEM_DRID;
    logic        DMEM_REQ, DMEM_WE, DMEM_ACK, DMEM_ERR;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [7:0]  DMEM_BE;
    logic        MEM_STALL, WB_V, WB_ECALL, MEM_PC_MUX;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_RFD, WB_CSRFD;
    logic [4:0]  WB_DRID;
    logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DMEM_BASE (BASE),
        .DMEM_SIZE (SIZE),
        .TIMEOUT   (TO)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_V          (MEM_V),
        .MEM_IR         (MEM_IR),
        .MEM_NPC        (MEM_NPC),
        .MEM_ALU_RESULT (MEM_ALU_RESULT),
        .MEM_SR2        (MEM_SR2),
        .MEM_BR_TAKEN   (MEM_BR_TAKEN),
        .MEM_RFD        (MEM_RFD),
        .MEM_CSRFD      (MEM_CSRFD),
        .MEM_DRID       (MEM_DRID),
        .MEM_ECALL      (MEM_ECALL),
        .FLUSH          (FLUSH),
        .DMEM_REQ       (DMEM_REQ),
        .DMEM_WE        (DMEM_WE),
        .DMEM_ADDR      (DMEM_ADDR),
        .DMEM_BE        (DMEM_BE),
        .DMEM_WDATA     (DMEM_WDATA),
        .DMEM_RDATA     (DMEM_RDATA),
        .DMEM_ACK       (DMEM_ACK),
        .DMEM_ERR       (DMEM_ERR),
        .MEM_STALL      (MEM_STALL),
        .WB_V           (WB_V),
        .WB_IR          (WB_IR),
        .WB_NPC         (WB_NPC),
        .WB_ALU_RESULT  (WB_ALU_RESULT),
        .WB_MEM_RESULT  (WB_MEM_RESULT),
        .WB_RFD         (WB_RFD),
        .WB_CSRFD       (WB_CSRFD),
        .WB_DRID        (WB_DRID),
        .WB_ECALL       (WB_ECALL),
        .MEM_PC_MUX     (MEM_PC_MUX),
        .MEM_LAM        (MEM_LAM),
        .MEM_LAF        (MEM_LAF),
        .MEM_SAM        (MEM_SAM),
        .MEM_SAF        (MEM_SAF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 = legal, 1 = misaligned, 2 = access fault
    function automatic int exp_fault(input bit st, input logic [2:0] f3,
                                     input longint unsigned a);
        longint unsigned sz = longint'(1) << f3[1:0];
        if (st ? (f3 > 3'd3) : (f3 == 3'd7)) return 2;
        if (a % sz != 0) return 1;
        if (a < BASE || a + sz > BASE + SIZE) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] flag_vec(input bit st, input int kind);
        if (kind == 1) return st ? 4'b0010 : 4'b1000;
        if (kind == 2) return st ? 4'b0001 : 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] rd, input int off,
                                             input logic [2:0] f3);
        int sz = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(off+k) +: 8];
        if (f3 < 3'd4 && sz < 8 && v[8*sz-1])
            for (int k = sz; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] exp_be(input int off, input logic [2:0] f3);
        logic [7:0] be = '0;
        for (int k = 0; k < (1 << f3[1:0]); k++) be[off+k] = 1'b1;
        return be;
    endfunction

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sr2, input logic [63:0] rdata, input int delay,
                         input bit err, input bit flush_idle, input int flush_wait);
        int          kind, n, off;
        bit          legal, killed, bfault;
        logic [63:0] npc;
        logic [4:0]  rd;
        kind  = exp_fault(st, f3, addr);
        legal = (kind == 0);
        off   = int'(addr[2:0]);
        npc   = {$urandom, $urandom};
        rd    = 5'($urandom);
        @(posedge CLK); #1;
        MEM_V = 1'b1;
        MEM_IR = {17'h0, f3, 5'd1, st ? OPC_ST : OPC_LD};
        MEM_ALU_RESULT = addr;
        MEM_SR2 = sr2;
        MEM_NPC = npc;
        MEM_DRID = rd;
        FLUSH = flush_idle;
        @(negedge CLK);
        check("stall_idle", MEM_STALL, legal && !flush_idle);
        if (!legal || flush_idle) begin
            @(posedge CLK); #1;
            MEM_V = 1'b0;
            FLUSH = 1'b0;
            @(negedge CLK);
            check("pre_wbv", WB_V, !flush_idle);
            check("pre_flags", {MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF},
                  flush_idle ? 4'b0000 : flag_vec(st, kind));
            check("pre_res", WB_MEM_RESULT, 64'd0);
            check("pre_noreq", DMEM_REQ, 1'b0);
            if (!flush_idle) check("pre_alu", WB_ALU_RESULT, addr);
            return;
        end
        killed = 1'b0;
        bfault = err || (delay > TO);
        n      = (delay > TO) ? TO : delay;
        for (int i = 0; i <= n; i++) begin
            @(posedge CLK); #1;
            FLUSH = (i == flush_wait);
            killed |= FLUSH;
            if (i == delay) begin
                if (err) DMEM_ERR = 1'b1;
                else DMEM_ACK = 1'b1;
                DMEM_RDATA = rdata;
            end
            @(negedge CLK);
            check("req_high", DMEM_REQ, 1'b1);
            check("stall_wait", MEM_STALL, (i != n) && !FLUSH);
            check("bubble", WB_V, 1'b0);
            if (i == 0) begin
                check("we", DMEM_WE, st);
                check("addr", DMEM_ADDR, {addr[63:3], 3'b000});
                check("be", DMEM_BE, exp_be(off, f3));
                if (st) check("wdata", DMEM_WDATA, sr2 << (8 * off));
            end
        end
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        DMEM_ERR = 1'b0;
        DMEM_RDATA = '0;
        FLUSH = 1'b0;
        MEM_V = 1'b0;
        @(negedge CLK);
        check("req_drop", DMEM_REQ, 1'b0);
        check("done_wbv", WB_V, !killed);
        check("done_flags", {MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF},
              (killed || !bfault) ? 4'b0000 : flag_vec(st, 2));
        check("done_res", WB_MEM_RESULT,
              (!killed && !st && !bfault) ? exp_load(rdata, off, f3) : 64'd0);
        if (!killed) begin
            check("done_drid", WB_DRID, rd);
            check("done_npc", WB_NPC, npc);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        check("wbv_pulse", WB_V, 1'b0);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f3;
        bit          st;
        int          dly, fw;
        RESET = 1'b1;
        MEM_V = 1'b0; MEM_IR = '0; MEM_NPC = '0; MEM_ALU_RESULT = '0; MEM_SR2 = '0;
        MEM_BR_TAKEN = 1'b0; MEM_RFD = '0; MEM_CSRFD = '0; MEM_DRID = '0;
        MEM_ECALL = 1'b0; FLUSH = 1'b0;
        DMEM_RDATA = '0; DMEM_ACK = 1'b0; DMEM_ERR = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_req", {DMEM_REQ, DMEM_WE, DMEM_BE}, 10'd0);
        check("rst_daddr", DMEM_ADDR | DMEM_WDATA, 64'd0);
        check("rst_wb", {WB_V, WB_ECALL, MEM_PC_MUX, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF,
                         WB_DRID}, 12'd0);
        check("rst_wbd", WB_NPC | WB_ALU_RESULT | WB_MEM_RESULT | WB_RFD | WB_CSRFD
                         | {32'd0, WB_IR}, 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Non-memory instruction passes straight through.
        @(posedge CLK); #1;
        MEM_V = 1'b1; MEM_IR = 32'h0020_81B3; MEM_ALU_RESULT = 64'h1234_5678_9ABC_DEF0;
        MEM_RFD = 64'h55; MEM_CSRFD = 64'hAA; MEM_ECALL = 1'b1; MEM_BR_TAKEN = 1'b1;
        MEM_DRID = 5'd3;
        @(negedge CLK);
        check("alu_stall", MEM_STALL, 1'b0);
        @(posedge CLK); #1;
        MEM_V = 1'b0; MEM_ECALL = 1'b0; MEM_BR_TAKEN = 1'b0;
        @(negedge CLK);
        check("alu_wbv", WB_V, 1'b1);
        check("alu_pcmux", MEM_PC_MUX, 1'b1);
        check("alu_res", WB_ALU_RESULT, 64'h1234_5678_9ABC_DEF0);
        check("alu_pass", {WB_IR, WB_RFD[7:0], WB_CSRFD[7:0], WB_ECALL, WB_DRID},
              {32'h0020_81B3, 8'h55, 8'hAA, 1'b1, 5'd3});
        check("alu_flags", {MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}, 4'b0000);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("inv_wbv", WB_V, 1'b0);

        do_op(0, 3'd3, 64'h8000_0008, 0, 64'h1122_3344_5566_7788, 3, 0, 0, -1);
        do_op(0, 3'd0, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, -1);
        do_op(0, 3'd4, 64'h8000_0003, 0, 64'h0000_0000_8000_0000, 1, 0, 0, -1);
        do_op(1, 3'd1, 64'h8000_0005, 64'h1234, 0, 0, 0, 0, -1);
        do_op(1, 3'd2, 64'h8000_0004, 64'hDEAD_BEEF, 0, 0, 0, 0, -1);
        do_op(0, 3'd2, 64'h8000_FFFE, 0, 0, 0, 0, 0, -1);
        do_op(0, 3'd3, 64'h7FFF_FFF8, 0, 0, 0, 0, 0, -1);
        do_op(0, 3'd3, BASE + SIZE - 8, 0, 64'hCAFE_F00D_0BAD_BEEF, 1, 0, 0, -1);
        do_op(0, 3'd3, BASE + SIZE, 0, 0, 0, 0, 0, -1);
        do_op(0, 3'd7, 64'h8000_0000, 0, 0, 0, 0, 0, -1);
        do_op(1, 3'd5, 64'h8000_0000, 0, 0, 0, 0, 0, -1);
        do_op(0, 3'd3, 64'h8000_0010, 0, 0, TO + 50, 0, 0, -1);
        do_op(1, 3'd3, 64'h8000_0020, 64'h0102_0304_0506_0708, 0, 2, 1, 0, -1);
        do_op(1, 3'd0, 64'h8000_0030, 64'hFF, 0, 0, 0, 1, -1);
        do_op(0, 3'd3, 64'h8000_0040, 0, 64'h77, 3, 0, 0, 1);

        // Reset while a transaction is outstanding drops REQ without a clock edge.
        @(posedge CLK); #1;
        MEM_V = 1'b1; MEM_IR = {17'h0, 3'd3, 5'd1, OPC_LD}; MEM_ALU_RESULT = BASE + 64'h48;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("mid_req", DMEM_REQ, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_req", DMEM_REQ, 1'b0);
        check("mid_rst_be", DMEM_BE, 8'd0);
        check("mid_rst_wbv", WB_V, 1'b0);
        @(posedge CLK); #1;
        MEM_V = 1'b0;
        RESET = 1'b0;
        do_op(0, 3'd5, 64'h8000_0102, 0, 64'h0000_F00D_0000_0000, 2, 0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = BASE - 64'd8 + 64'($urandom_range(0, 15));
                1:       a = BASE + SIZE - 64'd8 + 64'($urandom_range(0, 15));
                default: a = BASE + 64'($urandom_range(0, 32'hFFFF));
            endcase
            if ($urandom_range(0, 9) < 7) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            dly = $urandom_range(0, 4);
            fw  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, dly) : -1;
            do_op(st, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, dly,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, fw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
